arbitro_alu: RTL

Two-port round-robin arbiter and sequencer for the shared 4-bit ALU and its flag logic. It accepts operation requests (operands plus 4-bit selection) from two requesters over valid/ready handshakes, and drives the ALU from registered operands. It waits a parameterised settling latency, then captures the result and NZCV flags. It returns them to the originating requester over a valid/ready response channel and keeps a sticky copy of the last flags.

---
 rtl/arbitro_alu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/arbitro_alu.sv
// -----------------------------------------------------------------------------
// arbitro_alu
// Two-port round-robin arbiter and sequencer for a shared ALU. A request
// (operands + selection code) is accepted from one of two requesters over a
// valid/ready handshake. Its operands are registered onto the ALU inputs and
// held for LATENCIA cycles. The result and NZCV flags are then captured and
// returned to the originating requester over a valid/ready response channel.
// A sticky copy of the last completed flags is kept in 'banderas'.
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b/sel (N=0,1)   request channels; ready is combinational
//   alu_a, alu_b, alu_sel              registered operands/selection to the ALU
//   alu_resultado, alu_N/Z/C/V         ALU result and flag inputs
//   resp_valid/ready/id                response handshake and originating requester
//   resp_resultado, resp_banderas      captured result and {N,Z,C,V}
//   banderas                           sticky {N,Z,C,V} of last completed operation
//   ocupado                            high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module arbitro_alu #(
    parameter int ANCHO    = 3,
    parameter int LATENCIA = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ANCHO:0]   req0_a,
    input  logic [ANCHO:0]   req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ANCHO:0]   req1_a,
    input  logic [ANCHO:0]   req1_b,
    input  logic [3:0]       req1_sel,
    output logic [ANCHO:0]   alu_a,
    output logic [ANCHO:0]   alu_b,
    output logic [3:0]       alu_sel,
    input  logic [ANCHO:0]   alu_resultado,
    input  logic             alu_N,
    input  logic             alu_Z,
    input  logic             alu_C,
    input  logic             alu_V,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [ANCHO:0]   resp_resultado,
    output logic [3:0]       resp_banderas,
    output logic [3:0]       banderas,
    output logic             ocupado
);

    // Counter is loaded with LATENCIA-1 so that capture happens LATENCIA
    // edges after the accept edge.
    localparam logic [3:0] CNT_INI = 4'(LATENCIA - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EJECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t        estado_q;
    logic           prioridad_q;
    logic           id_q;
    logic [3:0]     cnt_q;
    logic [ANCHO:0] alu_a_q;
    logic [ANCHO:0] alu_b_q;
    logic [3:0]     alu_sel_q;
    logic           resp_valid_q;
    logic [ANCHO:0] resp_res_q;
    logic [3:0]     resp_band_q;
    logic [3:0]     banderas_q;
    logic           ocupado_q;

    logic           gnt0_d;
    logic           gnt1_d;
    logic           acepta_d;
    logic [ANCHO:0] a_d;
    logic [ANCHO:0] b_d;
    logic [3:0]     sel_d;
    logic [3:0]     flags_d;

    // Round-robin grant: the preferred requester wins on contention, a lone
    // requester always wins. The two terms are mutually exclusive.
    always_comb begin
        gnt0_d   = (estado_q == IDLE) & req0_valid & (~prioridad_q | ~req1_valid);
        gnt1_d   = (estado_q == IDLE) & req1_valid & ( prioridad_q | ~req0_valid);
        acepta_d = gnt0_d | gnt1_d;
        a_d      = gnt1_d ? req1_a   : req0_a;
        b_d      = gnt1_d ? req1_b   : req0_b;
        sel_d    = gnt1_d ? req1_sel : req0_sel;
        flags_d  = {alu_N, alu_Z, alu_C, alu_V};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= IDLE;
            prioridad_q  <= 1'b0;
            id_q         <= 1'b0;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_res_q   <= '0;
            resp_band_q  <= 4'd0;
            banderas_q   <= 4'd0;
            ocupado_q    <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (acepta_d) begin
                        alu_a_q     <= a_d;
                        alu_b_q     <= b_d;
                        alu_sel_q   <= sel_d;
                        id_q        <= gnt1_d;
                        prioridad_q <= ~gnt1_d;
                        cnt_q       <= CNT_INI;
                        ocupado_q   <= 1'b1;
                        estado_q    <= EJECUTA;
                    end
                end
                EJECUTA: begin
                    if (cnt_q == 4'd0) begin
                        resp_res_q   <= alu_resultado;
                        resp_band_q  <= flags_d;
                        banderas_q   <= flags_d;
                        resp_valid_q <= 1'b1;
                        estado_q     <= RESPONDE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESPONDE: begin
                    // Return to IDLE only; a new accept needs one IDLE cycle.
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        ocupado_q    <= 1'b0;
                        estado_q     <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    ocupado_q    <= 1'b0;
                    estado_q     <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready     = gnt0_d;
    assign req1_ready     = gnt1_d;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_sel        = alu_sel_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = id_q;
    assign resp_resultado = resp_res_q;
    assign resp_banderas  = resp_band_q;
    assign banderas       = banderas_q;
    assign ocupado        = ocupado_q;

endmodule
